// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory controller: op codes, FSM states, data width.
package dm_pkg;

  localparam int unsigned DataW = 32;

  typedef logic [2:0] op_t;
  localparam op_t OpByte  = 3'd0;
  localparam op_t OpHalf  = 3'd1;
  localparam op_t OpWord  = 3'd2;
  localparam op_t OpLeft  = 3'd3;
  localparam op_t OpRight = 3'd4;

  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StResp  = 2'd1;
  localparam state_t StClear = 2'd2;

endpackage

// File: rtl/dm_ctrl_if.sv
// Request/response bus between a load/store unit and dm_ctrl.
interface dm_ctrl_if
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  op_t               req_op;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DataW-1:0]  req_wdata;
  logic [DataW-1:0]  req_pc;
  logic              rsp_valid;
  logic [DataW-1:0]  rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_op, req_unsigned, req_addr, req_wdata, req_pc,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_op, req_unsigned, req_addr, req_wdata, req_pc,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_extend.sv
// Load-path formatting: lane select, sign/zero extension and LEFT/RIGHT merge.
// LEFT/RIGHT merge exists only when DM_LR_EN is defined.
module dm_extend
  import dm_pkg::*;
(
  input  op_t              op,
  input  logic             is_unsigned,
  input  logic [1:0]       offset,
  input  logic [DataW-1:0] word,
  input  logic [DataW-1:0] merge,
  output logic [DataW-1:0] result
);
  logic [7:0]  b_lane;
  logic [15:0] h_lane;

  assign b_lane = word[{offset, 3'b000} +: 8];
  assign h_lane = offset[1] ? word[31:16] : word[15:0];

`ifdef DM_LR_EN
  logic [1:0] roff;
  logic [4:0] sh_l, sh_r;
  assign roff = 2'd3 - offset;
  assign sh_l = {roff, 3'b000};
  assign sh_r = {offset, 3'b000};
`else
  logic unused_merge;
  assign unused_merge = ^merge;
`endif

  always_comb begin
    result = '0;
    case (op)
      OpByte:  result = {{24{~is_unsigned & b_lane[7]}}, b_lane};
      OpHalf:  result = {{16{~is_unsigned & h_lane[15]}}, h_lane};
      OpWord:  result = word;
`ifdef DM_LR_EN
      // Memory bytes fill the high end (LEFT) or low end (RIGHT); the rest keeps the register.
      OpLeft:  result = (word << sh_l) | (merge & ~(32'hFFFF_FFFF << sh_l));
      OpRight: result = (word >> sh_r) | (merge & ~(32'hFFFF_FFFF >> sh_r));
`endif
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/dm_ctrl.sv
// Single-port data memory controller with byte/half/word access, bulk clear and
// optional unaligned LEFT/RIGHT ops (enabled by defining DM_LR_EN).
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr_start,
  output logic       busy,
  dm_ctrl_if.slave   bus
);
  localparam int unsigned WIdxW = ADDR_W - 2;
  localparam int unsigned Depth = 2 ** WIdxW;

  logic [DataW-1:0] mem [Depth];

  state_t           state_q, state_d;
  logic [WIdxW-1:0] cnt_q, cnt_d;
  logic [WIdxW-1:0] widx;
  logic [1:0]       off;
  logic             accept, op_err;
  logic [3:0]       be;
  logic [DataW-1:0] st_data, rd_word, ld_data, rdata_q;
  logic             err_q;
  logic             unused_pc;

  assign unused_pc = ^bus.req_pc;
  assign widx      = bus.req_addr[ADDR_W-1:2];
  assign off       = bus.req_addr[1:0];
  assign rd_word   = mem[widx];

  assign bus.req_ready = (state_q == StIdle) && !clr_start;
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state_q == StClear);

  always_comb begin
    op_err = 1'b0;
    case (bus.req_op)
      OpByte:          op_err = 1'b0;
      OpHalf:          op_err = off[0];
      OpWord:          op_err = |off;
`ifdef DM_LR_EN
      OpLeft, OpRight: op_err = 1'b0;
`endif
      default:         op_err = 1'b1;
    endcase
  end

`ifdef DM_LR_EN
  logic [1:0] roff;
  assign roff = 2'd3 - off;
`endif

  // Store lane steering: st_data is pre-shifted so byte i of st_data lands in byte i of the word.
  always_comb begin
    be      = '0;
    st_data = bus.req_wdata;
    case (bus.req_op)
      OpByte: begin
        be      = 4'b0001 << off;
        st_data = {4{bus.req_wdata[7:0]}};
      end
      OpHalf: begin
        be      = off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus.req_wdata[15:0]}};
      end
      OpWord: be = 4'b1111;
`ifdef DM_LR_EN
      OpLeft: begin
        be      = 4'b1111 >> roff;
        st_data = bus.req_wdata >> {roff, 3'b000};
      end
      OpRight: begin
        be      = 4'b1111 << off;
        st_data = bus.req_wdata << {off, 3'b000};
      end
`endif
      default: be = '0;
    endcase
  end

  dm_extend u_extend (
    .op          (bus.req_op),
    .is_unsigned (bus.req_unsigned),
    .offset      (off),
    .word        (rd_word),
    .merge       (bus.req_wdata),
    .result      (ld_data)
  );

  // Memory array is intentionally not reset; only CLEAR zeroes it.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem[cnt_q] <= '0;
    end else if (accept && bus.req_we && !op_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (clr_start) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (accept) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rdata_q <= (bus.req_we || op_err) ? '0 : ld_data;
        err_q   <= op_err;
      end
    end
  end
endmodule

// File: doc/dm_ctrl.md
DM_CTRL -- requirements
Module: dm_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, byte-address width; memory depth is 2**(ADDR_W-2) 32-bit words.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req_valid input 1 (request present); req_ready output 1 (request accepted this edge if req_valid).
REQ-005 SHALL have ports req_we input 1 (store=1, load=0); req_op input 3 (BYTE=0, HALF=1, WORD=2, LEFT=3, RIGHT=4); req_unsigned input 1 (zero-extend loads).
REQ-006 SHALL have ports req_addr input ADDR_W (byte address); req_wdata input 32 (store data, or merge register for LEFT/RIGHT loads); req_pc input 32 (trace tag).
REQ-007 SHALL have ports rsp_valid output 1; rsp_rdata output 32; rsp_err output 1 (misaligned or unsupported op).
REQ-008 SHALL have ports clr_start input 1 (start memory clear); busy output 1 (clear in progress).

Function
REQ-009 SHALL implement FSM IDLE, RESP, CLEAR; req_ready = (state==IDLE) && !clr_start.
REQ-010 IDLE, clr_start=1: SHALL go to CLEAR, word counter=0; any concurrent req_valid is not accepted.
REQ-011 IDLE, request accepted: SHALL go to RESP; stores commit to memory on the accepting edge; loads sample memory on that edge.
REQ-012 RESP: rsp_valid=1 for exactly one cycle (no backpressure), then IDLE; minimum request spacing is 2 cycles.
REQ-013 CLEAR: SHALL write zero to word[counter] each cycle, busy=1, req_ready=0; after word DEPTH-1 go to IDLE. Clear takes DEPTH cycles.
REQ-014 clr_start outside IDLE SHALL be ignored.
REQ-015 BYTE store: writes byte addr; HALF: bytes {addr[ADDR_W-1:1],0..1}; WORD: 4 bytes of word addr[ADDR_W-1:2]; little-endian.
REQ-016 BYTE/HALF loads SHALL sign-extend, or zero-extend when req_unsigned=1; WORD loads return the full word.
REQ-017 Misaligned HALF (addr[0]=1) or WORD (addr[1:0]!=0) SHALL suppress the write and give rsp_err=1, rsp_rdata=0.
REQ-018 Byte offset b=addr[1:0]. LEFT store: mem bytes [b:0] = wdata bytes [3:3-b]. RIGHT store: mem bytes [3:b] = wdata bytes [3-b:0].
REQ-019 LEFT load: result bytes [3:3-b] = mem bytes [b:0]; the rest from req_wdata. RIGHT load: result bytes [3-b:0] = mem bytes [3:b]; the rest from req_wdata.
REQ-020 req_op values 5..7 SHALL be treated as unsupported (REQ-017 response).
REQ-021 rsp_rdata for stores SHALL be 0, rsp_err 0 unless REQ-017 applies.

Reset
REQ-022 reset_n low SHALL immediately force: state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0.
REQ-023 Memory array SHALL NOT be reset by reset_n; initial simulation content is all zero. Reset during CLEAR leaves memory partially cleared.

Configuration
REQ-024 Macro DM_LR_EN: when defined, LEFT/RIGHT ops SHALL behave per REQ-018/019. When undefined, they SHALL be unsupported (rsp_err=1, no write) and the merge logic SHALL be absent.

Structure
REQ-025 Package dm_pkg SHALL hold op encodings, FSM state enum and the width constant 32.
REQ-026 Sub-module dm_extend SHALL hold load lane select, byte/half extension and LEFT/RIGHT merge (combinational).

Verification
REQ-027 SW 0x12345678 @0x10, then LW @0x10 -> rsp_rdata=0x12345678, err=0, rsp_valid exactly one cycle after each accept.
REQ-028 SB 0x80 @0x21, LB @0x21 -> 0xFFFFFF80; LBU -> 0x00000080; LH @0x20 -> 0xFFFF8000.
REQ-029 LW @0x12 -> err=1, rdata=0; SH @0x13 -> err=1, word 0x10 unchanged.
REQ-030 DM_LR_EN defined: word 0x44332211 @0x40; LEFT load @0x41, req_wdata 0xAABBCCDD -> 0x2211CCDD; RIGHT load @0x41 -> 0xAA443322.
REQ-031 clr_start with simultaneous req_valid -> req_ready=0, busy=1 for DEPTH cycles, then all words read 0.
REQ-032 reset_n low mid-CLEAR -> IDLE, busy=0 at once; the next request is accepted in the first cycle after release.
